// File: rtl/i2s_rx_axis_if.sv
//==============================================================================
// Module      : i2s_rx_axis_if
// Description : AXI-Stream sample channel (data/valid/ready/last) for the
//               I2S receiver output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface i2s_rx_axis_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

`default_nettype wire

// File: rtl/i2s_rx_axis.sv
//==============================================================================
// Module      : i2s_rx_axis
// Description : I2S line-in capture: generates MCLK/SCLK/LRCK, deserialises
//               24-bit stereo words and streams them out through a 2-deep FIFO.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module i2s_rx_axis #(
    parameter int DATA_WIDTH     = 24,
    parameter int SCLK_DIV_LOG2  = 3,
    parameter int SLOT_BITS_LOG2 = 5
) (
    input  wire logic        axis_clk,
    input  wire logic        reset,
    output logic             rx_mclk,
    output logic             rx_sclk,
    output logic             rx_lrck,
    input  wire logic        rx_sdin,
    i2s_rx_axis_if.master    m_axis,
    output logic             overrun
);

    localparam int c_CNT_W = SCLK_DIV_LOG2 + SLOT_BITS_LOG2 + 1;
    localparam logic [c_CNT_W-1:0]        c_CNT_ONE      = c_CNT_W'(1);
    // Strobe one cycle past the SCLK rising edge, i.e. mid SCLK-high.
    localparam logic [SCLK_DIV_LOG2-1:0]  c_STROBE_PHASE = SCLK_DIV_LOG2'((1 << (SCLK_DIV_LOG2 - 1)) + 1);
    localparam logic [SLOT_BITS_LOG2-1:0] c_FIRST_BIT    = SLOT_BITS_LOG2'(1);
    localparam logic [SLOT_BITS_LOG2-1:0] c_LAST_BIT     = SLOT_BITS_LOG2'(DATA_WIDTH);

    logic [c_CNT_W-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_sreg;
    logic                  r_pending;
    logic                  r_pend_last;
    logic [DATA_WIDTH:0]   r_mem [2];
    logic                  r_wr;
    logic                  r_rd;
    logic [1:0]            r_count;
    logic                  r_overrun;

    logic [SCLK_DIV_LOG2-1:0]  w_phase;
    logic [SLOT_BITS_LOG2-1:0] w_bit;
    logic                      w_ch;
    logic                      w_strobe;
    logic                      w_payload;
    logic                      w_word_done;
    logic                      w_bypass;
    logic                      w_full;
    logic                      w_valid;
    logic                      w_pop;
    logic                      w_store;
    logic                      w_consume;
    logic                      w_drop;

    assign w_phase     = r_cnt[SCLK_DIV_LOG2-1:0];
    assign w_bit       = r_cnt[c_CNT_W-2:SCLK_DIV_LOG2];
    assign w_ch        = r_cnt[c_CNT_W-1];
    assign w_strobe    = (w_phase == c_STROBE_PHASE);
    assign w_payload   = (w_bit >= c_FIRST_BIT) && (w_bit <= c_LAST_BIT);
    assign w_word_done = w_strobe && (w_bit == c_LAST_BIT);

    // A just-completed word is presented straight from the shift register
    // when the FIFO is empty, so it is visible in its push cycle.
    assign w_bypass  = (r_count == 2'd0);
    assign w_full    = (r_count == 2'd2);
    assign w_valid   = !w_bypass || r_pending;
    assign w_pop     = w_valid && m_axis.ready;
    assign w_store   = r_pending && !(w_bypass && w_pop) && (!w_full || w_pop);
    assign w_consume = w_pop && !w_bypass;
    assign w_drop    = r_pending && w_full && !w_pop;

    assign rx_mclk      = axis_clk;
    assign rx_sclk      = r_cnt[SCLK_DIV_LOG2-1];
    assign rx_lrck      = w_ch;
    assign m_axis.valid = w_valid;
    assign m_axis.data  = w_bypass ? r_sreg      : r_mem[r_rd][DATA_WIDTH-1:0];
    assign m_axis.last  = w_bypass ? r_pend_last : r_mem[r_rd][DATA_WIDTH];
    assign overrun      = r_overrun;

    always_ff @(posedge axis_clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_sreg      <= '0;
            r_pending   <= 1'b0;
            r_pend_last <= 1'b0;
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_count     <= 2'd0;
            r_overrun   <= 1'b0;
        end else begin
            r_cnt       <= r_cnt + c_CNT_ONE;
            r_pending   <= w_word_done;
            r_pend_last <= w_ch;
            if (w_strobe && w_payload) begin
                r_sreg <= {r_sreg[DATA_WIDTH-2:0], rx_sdin};
            end
            if (w_store) begin
                r_mem[r_wr] <= {r_pend_last, r_sreg};
                r_wr        <= !r_wr;
            end
            if (w_consume) begin
                r_rd <= !r_rd;
            end
            r_count <= r_count + {1'b0, w_store} - {1'b0, w_consume};
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2s_rx_axis.sv
//==============================================================================
// Module      : tb_i2s_rx_axis
// Description : Directed self-checking bench for i2s_rx_axis.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_i2s_rx_axis;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx_mclk;
    logic rx_sclk;
    logic rx_lrck;
    logic rx_sdin = 1'b0;
    logic overrun;

    i2s_rx_axis_if #(.DATA_WIDTH(24)) axis_if ();

    i2s_rx_axis #(
        .DATA_WIDTH     (24),
        .SCLK_DIV_LOG2  (3),
        .SLOT_BITS_LOG2 (5)
    ) dut (
        .axis_clk (clk),
        .reset    (reset),
        .rx_mclk  (rx_mclk),
        .rx_sclk  (rx_sclk),
        .rx_lrck  (rx_lrck),
        .rx_sdin  (rx_sdin),
        .m_axis   (axis_if.master),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          tb_t     = 0;
    logic [23:0] l_word   = 24'h0;
    logic [23:0] r_word   = 24'h0;
    logic        filler   = 1'b0;

    // Clock-output statistics gathered while stats_on is set.
    logic stats_on     = 1'b0;
    logic prev_sclk    = 1'b0;
    logic prev_lrck    = 1'b0;
    int   sclk_hi      = 0;
    int   lrck_hi      = 0;
    int   sclk_rises   = 0;
    int   lrck_edges   = 0;
    int   lrck_bad     = 0;
    int   bad_period   = 0;
    int   last_sclk_up = -1;
    int   last_lrck_up = -1;

    function automatic logic sdin_bit(input int t);
        int          c;
        int          b;
        logic [23:0] w;
        c = t % 512;
        b = (c >> 3) & 31;
        w = (c >= 256) ? r_word : l_word;
        if (b >= 1 && b <= 24) return w[24-b];
        return filler;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample_stats();
        if (rx_sclk) sclk_hi++;
        if (rx_lrck) lrck_hi++;
        if (rx_sclk && !prev_sclk) begin
            sclk_rises++;
            if (last_sclk_up >= 0 && tb_t - last_sclk_up != 8) bad_period++;
            last_sclk_up = tb_t;
        end
        if (rx_lrck !== prev_lrck) begin
            lrck_edges++;
            if (rx_sclk !== 1'b0) lrck_bad++;
            if (rx_lrck) begin
                if (last_lrck_up >= 0 && tb_t - last_lrck_up != 512) bad_period++;
                last_lrck_up = tb_t;
            end
        end
        prev_sclk = rx_sclk;
        prev_lrck = rx_lrck;
    endtask

    task automatic advance_to(input int target);
        while (tb_t < target) begin
            @(negedge clk);
            tb_t++;
            rx_sdin = sdin_bit(tb_t);
            if (stats_on) sample_stats();
        end
    endtask

    // One reset cycle; the cycle in progress afterwards has cnt = 0.
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        tb_t    = 0;
        rx_sdin = sdin_bit(0);
    endtask

    task automatic check_out(input string tag, input logic v, input logic [23:0] d,
                             input logic l);
        check({tag, ".valid"}, 32'(axis_if.valid), 32'(v));
        check({tag, ".data"},  32'(axis_if.data),  32'(d));
        check({tag, ".last"},  32'(axis_if.last),  32'(l));
    endtask

    task automatic check_reset_state(input string tag);
        check_out(tag, 1'b0, 24'h0, 1'b0);
        check({tag, ".overrun"}, 32'(overrun), 32'd0);
        check({tag, ".sclk"},    32'(rx_sclk), 32'd0);
        check({tag, ".lrck"},    32'(rx_lrck), 32'd0);
    endtask

    initial begin
        axis_if.ready = 1'b0;

        // Reset state and nominal stereo capture with ready held high
        l_word = 24'hA5A5A5;
        r_word = 24'h5A5A5A;
        filler = 1'b0;
        do_reset();
        check_reset_state("reset");
        axis_if.ready = 1'b1;
        prev_sclk = rx_sclk;
        prev_lrck = rx_lrck;
        stats_on  = 1'b1;
        advance_to(197);
        check("nom.pre_valid", 32'(axis_if.valid), 32'd0);
        advance_to(198);
        check_out("nom.left", 1'b1, 24'hA5A5A5, 1'b0);
        advance_to(199);
        check("nom.left_1cyc", 32'(axis_if.valid), 32'd0);
        advance_to(454);
        check_out("nom.right", 1'b1, 24'h5A5A5A, 1'b1);
        advance_to(455);
        check("nom.right_1cyc", 32'(axis_if.valid), 32'd0);
        advance_to(710);
        check_out("nom.left2", 1'b1, 24'hA5A5A5, 1'b0);
        advance_to(966);
        check_out("nom.right2", 1'b1, 24'h5A5A5A, 1'b1);
        check("nom.overrun", 32'(overrun), 32'd0);
        advance_to(1024);
        stats_on = 1'b0;
        check("clk.sclk_high",  32'(sclk_hi),    32'd512);
        check("clk.sclk_rises", 32'(sclk_rises), 32'd128);
        check("clk.lrck_high",  32'(lrck_hi),    32'd512);
        check("clk.lrck_edges", 32'(lrck_edges), 32'd4);
        check("clk.lrck_sclk",  32'(lrck_bad),   32'd0);
        check("clk.periods",    32'(bad_period), 32'd0);

        // Framing: ones outside the payload bits must not leak in
        l_word = 24'h000000;
        r_word = 24'h800001;
        filler = 1'b1;
        do_reset();
        advance_to(198);
        check_out("frm.zero", 1'b1, 24'h000000, 1'b0);
        advance_to(454);
        check_out("frm.msb_lsb", 1'b1, 24'h800001, 1'b1);

        // Backpressure across three words, third one dropped
        filler = 1'b0;
        l_word = 24'h111111;
        r_word = 24'h222222;
        axis_if.ready = 1'b0;
        do_reset();
        advance_to(198);
        check_out("bp.l1", 1'b1, 24'h111111, 1'b0);
        advance_to(300);
        l_word = 24'h333333;
        check_out("bp.hold", 1'b1, 24'h111111, 1'b0);
        advance_to(454);
        check_out("bp.r1_held", 1'b1, 24'h111111, 1'b0);
        check("bp.no_ovr_yet", 32'(overrun), 32'd0);
        advance_to(711);
        check("bp.overrun", 32'(overrun), 32'd1);
        check_out("bp.l2_held", 1'b1, 24'h111111, 1'b0);
        advance_to(720);
        axis_if.ready = 1'b1;
        check_out("bp.pop1", 1'b1, 24'h111111, 1'b0);
        r_word = 24'h444444;
        advance_to(721);
        check_out("bp.pop2", 1'b1, 24'h222222, 1'b1);
        advance_to(722);
        check("bp.empty", 32'(axis_if.valid), 32'd0);
        advance_to(966);
        check_out("bp.r2", 1'b1, 24'h444444, 1'b1);
        check("bp.sticky", 32'(overrun), 32'd1);

        // Full FIFO with a pop in the push cycle of the third word
        l_word = 24'h0A0B0C;
        r_word = 24'h0D0E0F;
        axis_if.ready = 1'b0;
        do_reset();
        advance_to(300);
        l_word = 24'h123456;
        advance_to(710);
        axis_if.ready = 1'b1;
        check_out("full.head", 1'b1, 24'h0A0B0C, 1'b0);
        advance_to(711);
        axis_if.ready = 1'b0;
        check_out("full.after_pop", 1'b1, 24'h0D0E0F, 1'b1);
        check("full.no_overrun", 32'(overrun), 32'd0);
        advance_to(720);
        axis_if.ready = 1'b1;
        check_out("full.second", 1'b1, 24'h0D0E0F, 1'b1);
        advance_to(721);
        check_out("full.third", 1'b1, 24'h123456, 1'b0);
        advance_to(722);
        check("full.empty", 32'(axis_if.valid), 32'd0);
        check("full.overrun_end", 32'(overrun), 32'd0);

        // Reset in the middle of a left word
        l_word = 24'h654321;
        r_word = 24'h0FEDCB;
        axis_if.ready = 1'b0;
        do_reset();
        advance_to(1124);
        check("mid.pre_valid", 32'(axis_if.valid), 32'd1);
        check("mid.pre_overrun", 32'(overrun), 32'd1);
        l_word = 24'h13579B;
        do_reset();
        axis_if.ready = 1'b1;
        check_reset_state("mid.reset");
        advance_to(197);
        check("mid.no_partial", 32'(axis_if.valid), 32'd0);
        advance_to(198);
        check_out("mid.left", 1'b1, 24'h13579B, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
